modarith_sequencer: RTL and testbench

Command-level controller in front of the modular-arithmetic accelerator (add/sub/mod/R-setup/mult/exp datapath, 3-bit control code, `start`/`finished` handshake). Accepts one operation at a time over a valid/ready command port. Runs the R-setup pass automatically before mult/exp whenever the Montgomery constants are stale. Holds operands and control stable for the whole operation, then returns a registered result over a valid/ready response port.

---
 rtl/modarith_pkg.sv | 29 ++
 rtl/modarith_seq_watchdog.sv | 24 ++
 rtl/modarith_sequencer.sv | 130 +++++++++++++
 tb/tb_modarith_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/modarith_pkg.sv
// modarith_pkg: opcodes, sequencer states and helpers shared by the modular-arithmetic sequencer
package modarith_pkg;

  typedef enum logic [2:0] {
    OP_ADD     = 3'b000,
    OP_SUB     = 3'b001,
    OP_MOD     = 3'b010,
    OP_RSET    = 3'b011,
    OP_MULT    = 3'b100,
    OP_EXP     = 3'b101,
    OP_ILLEGAL = 3'b110
  } op_e;

  localparam logic [2:0] OP_RSETUP = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RS_START,
    S_RS_WAIT,
    S_OP_START,
    S_OP_WAIT,
    S_RESP
  } state_e;

  function automatic logic is_montgomery(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_EXP);
  endfunction

endpackage

// File: rtl/modarith_seq_watchdog.sv
// modarith_seq_watchdog: counts wait cycles of one accelerator pass and flags when LIMIT is reached
module modarith_seq_watchdog #(
  parameter int unsigned LIMIT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);
  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] r_cnt;

  // expired is raised in the LIMIT-th consecutive wait cycle
  assign o_expired = i_run && (r_cnt == W'(LIMIT - 1));

  // wait-cycle counter, restarted by every start state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_run && !o_expired) r_cnt <= r_cnt + W'(1);

endmodule

// File: rtl/modarith_sequencer.sv
// modarith_sequencer: command/response front end for the modular-arithmetic accelerator with automatic R setup
// Optional watchdog on accelerator passes: define MODARITH_SEQ_TIMEOUT_EN.
module modarith_sequencer
  import modarith_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  input  logic [DATA_WIDTH-1:0] cmd_mod,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_error,
  output logic [DATA_WIDTH-1:0] acc_a,
  output logic [DATA_WIDTH-1:0] acc_b,
  output logic [DATA_WIDTH-1:0] acc_mod,
  output logic [2:0]            acc_control,
  output logic                  acc_start,
  input  logic [DATA_WIDTH-1:0] acc_result,
  input  logic                  acc_finished
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_e                r_state;
  logic [2:0]            r_op;
  logic                  r_first;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_mod;
  logic                  w_err;
  logic                  w_need_rs;
  logic                  w_timeout;

  assign cmd_ready = r_state == S_IDLE;
  assign rsp_valid = r_state == S_RESP;
  assign w_err = (cmd_op[2:1] == 2'b11) || (cmd_mod == '0) || (is_montgomery(cmd_op) && !cmd_mod[0]);
  assign w_need_rs = (cmd_op == OP_RSETUP) || (is_montgomery(cmd_op) && (!r_valid || r_mod != cmd_mod));

`ifdef MODARITH_SEQ_TIMEOUT_EN
  modarith_seq_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (r_state == S_RS_START || r_state == S_OP_START),
    .i_run    (r_state == S_RS_WAIT || r_state == S_OP_WAIT),
    .o_expired(w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // command sequencing: accept, optional R-setup pass, user pass, held response
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_first     <= 1'b0;
      r_valid     <= 1'b0;
      r_mod       <= '0;
      rsp_result  <= '0;
      rsp_error   <= 1'b0;
      acc_a       <= '0;
      acc_b       <= '0;
      acc_mod     <= '0;
      acc_control <= '0;
      acc_start   <= 1'b0;
    end else begin
      acc_start <= 1'b0;
      case (r_state)
        S_IDLE: if (cmd_valid) begin
          acc_a       <= cmd_a;
          acc_b       <= cmd_b;
          acc_mod     <= cmd_mod;
          acc_control <= w_need_rs ? OP_RSETUP : cmd_op;
          r_op        <= cmd_op;
          rsp_error   <= w_err;
          rsp_result  <= '0;
          acc_start   <= !w_err;
          r_state     <= w_err ? S_RESP : (w_need_rs ? S_RS_START : S_OP_START);
        end
        S_RS_START: begin
          r_first <= 1'b1;
          r_state <= S_RS_WAIT;
        end
        S_RS_WAIT: if (r_first) r_first <= 1'b0;
        else if (acc_finished) begin
          r_valid <= 1'b1;
          r_mod   <= acc_mod;
          if (r_op == OP_RSETUP) begin
            rsp_result <= DATA_WIDTH'(1);
            r_state    <= S_RESP;
          end else begin
            acc_control <= r_op;
            acc_start   <= 1'b1;
            r_state     <= S_OP_START;
          end
        end else if (w_timeout) begin
          r_valid    <= 1'b0;
          rsp_result <= '0;
          rsp_error  <= 1'b1;
          r_state    <= S_RESP;
        end
        S_OP_START: begin
          r_first <= 1'b1;
          r_state <= S_OP_WAIT;
        end
        S_OP_WAIT: if (r_first) r_first <= 1'b0;
        else if (acc_finished) begin
          rsp_result <= acc_result;
          r_state    <= S_RESP;
        end else if (w_timeout) begin
          r_valid    <= 1'b0;
          rsp_result <= '0;
          rsp_error  <= 1'b1;
          r_state    <= S_RESP;
        end
        S_RESP: if (rsp_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end

endmodule

// File: tb/tb_modarith_sequencer.sv
// tb_modarith_sequencer: directed self-checking bench for modarith_sequencer
module tb_modarith_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [7:0] cmd_a = '0, cmd_b = '0, cmd_mod = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_result;
  logic       rsp_error;
  logic [7:0] acc_a, acc_b, acc_mod;
  logic [2:0] acc_control;
  logic       acc_start;
  logic [7:0] acc_result = '0;
  logic       acc_finished = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] ctl_q[$];

  modarith_sequencer #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_mod(cmd_mod),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_error(rsp_error),
    .acc_a(acc_a), .acc_b(acc_b), .acc_mod(acc_mod), .acc_control(acc_control),
    .acc_start(acc_start), .acc_result(acc_result), .acc_finished(acc_finished)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && acc_start) ctl_q.push_back(acc_control);

  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
    @(posedge clk); #1;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_mod = m; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_rsp;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_cmp++;
    if ({cmd_ready, rsp_valid, rsp_result, rsp_error, acc_start, acc_control, acc_a, acc_b, acc_mod} !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 3'd0, 24'd0}) begin
      n_bad++;
      $display("FAIL reset_values got rdy=%b vld=%b res=%0d err=%b st=%b ctl=%0d a=%0d b=%0d m=%0d want 1 0 0 0 0 0 0 0 0",
               cmd_ready, rsp_valid, rsp_result, rsp_error, acc_start, acc_control, acc_a, acc_b, acc_mod);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add;
    int lat;
    ctl_q.delete();
    acc_finished = 1'b1; acc_result = 8'd3;
    issue(3'b000, 8'd7, 8'd9, 8'd13);
    n_cmp++;
    if ({acc_start, acc_control, acc_a, acc_b, acc_mod} !== {1'b1, 3'd0, 8'd7, 8'd9, 8'd13}) begin
      n_bad++;
      $display("FAIL add_start got st=%b ctl=%0d a=%0d b=%0d m=%0d want 1 0 7 9 13", acc_start, acc_control, acc_a, acc_b, acc_mod);
    end
    wait_rsp(lat);
    n_cmp++;
    if (lat !== 4) begin n_bad++; $display("FAIL add_latency got %0d want 4", lat); end
    n_cmp++;
    if ({rsp_result, rsp_error} !== {8'd3, 1'b0}) begin
      n_bad++; $display("FAIL add_result got %0d err=%b want 3 err=0", rsp_result, rsp_error);
    end
    finish_rsp();
    n_cmp++;
    if (ctl_q.size() != 1) begin n_bad++; $display("FAIL add_pulses got %0d want 1", ctl_q.size()); end
  endtask

  task automatic test_rcache;
    int lat;
    logic [7:0] mods [3] = '{8'd13, 8'd13, 8'd11};
    int lats [3] = '{7, 4, 7};
    acc_finished = 1'b1; acc_result = 8'd4;
    for (int i = 0; i < 3; i++) begin
      ctl_q.delete();
      issue(3'b100, 8'd5, 8'd6, mods[i]);
      wait_rsp(lat);
      n_cmp++;
      if (lat !== lats[i]) begin n_bad++; $display("FAIL rcache_latency[%0d] got %0d want %0d", i, lat, lats[i]); end
      n_cmp++;
      if ({rsp_result, rsp_error} !== {8'd4, 1'b0}) begin
        n_bad++; $display("FAIL rcache_result[%0d] got %0d err=%b want 4 err=0", i, rsp_result, rsp_error);
      end
      finish_rsp();
      n_cmp++;
      if (lats[i] == 7 ? (ctl_q.size() != 2 || ctl_q[0] !== 3'b011 || ctl_q[1] !== 3'b100)
                       : (ctl_q.size() != 1 || ctl_q[0] !== 3'b100)) begin
        n_bad++; $display("FAIL rcache_controls[%0d] got %0d pulses want %0d", i, ctl_q.size(), lats[i] == 7 ? 2 : 1);
      end
    end
  endtask

  task automatic test_errors;
    int lat;
    logic [2:0] ops [3] = '{3'b100, 3'b111, 3'b000};
    logic [7:0] mods [3] = '{8'd12, 8'd13, 8'd0};
    acc_finished = 1'b1; acc_result = 8'd4;
    for (int i = 0; i < 3; i++) begin
      ctl_q.delete();
      issue(ops[i], 8'd5, 8'd6, mods[i]);
      wait_rsp(lat);
      n_cmp++;
      if (lat !== 1) begin n_bad++; $display("FAIL err_latency[%0d] got %0d want 1", i, lat); end
      n_cmp++;
      if ({rsp_result, rsp_error} !== {8'd0, 1'b1}) begin
        n_bad++; $display("FAIL err_response[%0d] got %0d err=%b want 0 err=1", i, rsp_result, rsp_error);
      end
      finish_rsp();
      n_cmp++;
      if (ctl_q.size() != 0) begin n_bad++; $display("FAIL err_no_start[%0d] got %0d pulses want 0", i, ctl_q.size()); end
    end
    ctl_q.delete();
    issue(3'b100, 8'd3, 8'd3, 8'd11);
    wait_rsp(lat);
    finish_rsp();
    n_cmp++;
    if (lat !== 4 || ctl_q.size() != 1) begin
      n_bad++; $display("FAIL err_cache_kept got lat=%0d pulses=%0d want 4 1", lat, ctl_q.size());
    end
  endtask

  task automatic test_backpressure;
    int lat;
    acc_finished = 1'b1; acc_result = 8'd3;
    issue(3'b001, 8'd9, 8'd6, 8'd13);
    wait_rsp(lat);
    acc_result = 8'd9;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({rsp_valid, rsp_result, cmd_ready} !== {1'b1, 8'd3, 1'b0}) begin
        n_bad++; $display("FAIL bp_hold[%0d] got vld=%b res=%0d rdy=%b want 1 3 0", i, rsp_valid, rsp_result, cmd_ready);
      end
      @(posedge clk); #1;
    end
    finish_rsp();
    n_cmp++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      n_bad++; $display("FAIL bp_release got rdy=%b vld=%b want 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    acc_finished = 1'b0;
    issue(3'b101, 8'd2, 8'd3, 8'd11);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if ({rsp_valid, acc_start, acc_control} !== {1'b0, 1'b0, 3'b101}) begin
      n_bad++; $display("FAIL mid_busy got vld=%b st=%b ctl=%0d want 0 0 5", rsp_valid, acc_start, acc_control);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_ready, rsp_valid, rsp_result, rsp_error, acc_start, acc_control, acc_a, acc_b, acc_mod} !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 3'd0, 24'd0}) begin
      n_bad++; $display("FAIL mid_reset_values got rdy=%b vld=%b ctl=%0d a=%0d m=%0d want 1 0 0 0 0",
                        cmd_ready, rsp_valid, acc_control, acc_a, acc_mod);
    end
    @(negedge clk); rst_n = 1'b1;
    ctl_q.delete();
    acc_finished = 1'b1; acc_result = 8'd8;
    issue(3'b100, 8'd5, 8'd6, 8'd11);
    wait_rsp(lat);
    finish_rsp();
    n_cmp++;
    if (lat !== 7 || ctl_q.size() != 2 || rsp_result !== 8'd8) begin
      n_bad++; $display("FAIL mid_rerun_rsetup got lat=%0d pulses=%0d res=%0d want 7 2 8", lat, ctl_q.size(), rsp_result);
    end
  endtask

`ifdef MODARITH_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    int lat;
    acc_finished = 1'b0;
    issue(3'b010, 8'd20, 8'd0, 8'd7);
    wait_rsp(lat);
    n_cmp++;
    if (lat !== 18 || rsp_error !== 1'b1 || rsp_result !== 8'd0) begin
      n_bad++; $display("FAIL timeout got lat=%0d err=%b res=%0d want 18 1 0", lat, rsp_error, rsp_result);
    end
    finish_rsp();
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_rcache();
    test_errors();
    test_backpressure();
    test_reset_mid();
`ifdef MODARITH_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
